// File: rtl/io_bus_pkg.sv
// Shared types and constants for the RISC5 I/O-space controller.
// Optional build macro used by io_bus_ctrl: IO_TMO_EN (access timeout).
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } io_state_e;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_DONE   = DONE;

  // The I/O window is the top 64 bytes; slots are word-spaced inside it.
  localparam int IO_WIN_LSB = 6;
  localparam int IDX_LSB    = 2;
  localparam int IDX_W      = IO_WIN_LSB - IDX_LSB;

  localparam logic [31:0] ERR_DATA = 32'h0;

endpackage

// File: rtl/io_bus_ctrl_if.sv
// CPU-side and slot-side signals of the I/O controller.
// master = cpu plus peripherals, slave = io_bus_ctrl.
interface io_bus_ctrl_if #(
  parameter int NUM_SLOTS = 8,
  parameter int ADR_W     = 24,
  parameter int DATA_W    = 32
);
  logic [ADR_W-1:0]            adr;
  logic                        rd;
  logic                        wr;
  logic                        io_en;
  logic                        memwait;
  logic [DATA_W-1:0]           dout;
  logic [NUM_SLOTS-1:0]        slot_en;
  logic                        slot_rd;
  logic                        slot_wr;
  logic [NUM_SLOTS*DATA_W-1:0] slot_dout;
  logic [NUM_SLOTS-1:0]        slot_rdy;
  logic                        bus_err;
  logic                        err_clr;

  modport master (
    output adr, rd, wr, slot_dout, slot_rdy, err_clr,
    input  io_en, memwait, dout, slot_en, slot_rd, slot_wr, bus_err
  );

  modport slave (
    input  adr, rd, wr, slot_dout, slot_rdy, err_clr,
    output io_en, memwait, dout, slot_en, slot_rd, slot_wr, bus_err
  );

endinterface

// File: rtl/io_slot_dec.sv
// Word index inside the I/O window to one-hot slot select.
// in_range is low for indices that have no slot behind them.
module io_slot_dec
  import io_bus_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic [IDX_W-1:0]     idx,
  output logic [NUM_SLOTS-1:0] slot_1h,
  output logic                 in_range
);

  always_comb begin
    slot_1h  = '0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == IDX_W'(i)) begin
        slot_1h[i] = 1'b1;
        in_range   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// I/O-space controller: window decode, slot strobes, wait states, read-data register.
// Define IO_TMO_EN to build the ACCESS timeout counter and its error path.
//
// state  | meaning
// IDLE   | no access in progress; a decoded access starts here
// ACCESS | slot selected, waiting for that slot's ready (or the timeout)
// DONE   | result registered; memwait released for exactly this cycle
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int ADR_W      = 24,
  parameter int DATA_W     = 32,
  parameter int TMO_CYCLES = 15
) (
  input  logic         clk,
  input  logic         rst,
  io_bus_ctrl_if.slave bus
);

  logic [1:0]           state;
  logic [IDX_W-1:0]     idx;
  logic                 io_en;
  logic                 access;
  logic [NUM_SLOTS-1:0] sel_1h;
  logic                 in_range;
  logic                 acc_rd;
  logic                 slot_hit;
  logic                 tmo_hit;
  logic [DATA_W-1:0]    rdata;
  logic [DATA_W-1:0]    dout_q;
  logic [NUM_SLOTS-1:0] slot_en_q;
  logic                 slot_rd_q;
  logic                 slot_wr_q;
  logic                 bus_err_q;
  logic                 unused_adr;

  assign idx        = bus.adr[IO_WIN_LSB-1:IDX_LSB];
  assign io_en      = &bus.adr[ADR_W-1:IO_WIN_LSB];
  assign access     = io_en & (bus.rd | bus.wr);
  assign unused_adr = ^bus.adr[IDX_LSB-1:0];

  io_slot_dec #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_dec (
    .idx      (idx),
    .slot_1h  (sel_1h),
    .in_range (in_range)
  );

  // The held select, not the live address, qualifies ready and read data.
  assign slot_hit = |(slot_en_q & bus.slot_rdy);

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_en_q[i]) rdata = bus.slot_dout[i*DATA_W +: DATA_W];
    end
  end

`ifdef IO_TMO_EN
  localparam int CNT_W = $clog2(TMO_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Fires on the TMO_CYCLES-th ACCESS cycle without ready.
  assign tmo_hit = (state == ST_ACCESS) && !slot_hit &&
                   (tmo_cnt == CNT_W'(TMO_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state != ST_ACCESS) begin
      tmo_cnt <= '0;
    end else if (!slot_hit && (tmo_cnt != CNT_W'(TMO_CYCLES))) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dout_q    <= '0;
      slot_en_q <= '0;
      slot_rd_q <= 1'b0;
      slot_wr_q <= 1'b0;
      bus_err_q <= 1'b0;
      acc_rd    <= 1'b0;
    end else begin
      slot_rd_q <= 1'b0;
      slot_wr_q <= 1'b0;
      // Any error set below overrides a clear in the same cycle.
      if (bus.err_clr) bus_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (in_range) begin
              state     <= ST_ACCESS;
              slot_en_q <= sel_1h;
              slot_rd_q <= ~bus.wr;
              slot_wr_q <= bus.wr;
              acc_rd    <= ~bus.wr;
            end else begin
              state     <= ST_DONE;
              dout_q    <= DATA_W'(ERR_DATA);
              bus_err_q <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (slot_hit) begin
            if (acc_rd) dout_q <= rdata;
            slot_en_q <= '0;
            state     <= ST_DONE;
          end else if (tmo_hit) begin
            dout_q    <= DATA_W'(ERR_DATA);
            bus_err_q <= 1'b1;
            slot_en_q <= '0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          slot_en_q <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          slot_en_q <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset also releases the stall so the cpu is never held during reset.
  assign bus.memwait = access & (state != ST_DONE) & ~rst;
  assign bus.io_en   = io_en;
  assign bus.dout    = dout_q;
  assign bus.slot_en = slot_en_q;
  assign bus.slot_rd = slot_rd_q;
  assign bus.slot_wr = slot_wr_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: stimulus queues the expected completion,
// a negedge monitor measures each access and compares when memwait releases.
module tb_io_bus_ctrl;

  localparam int NS = 8;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TMO = 15;

  logic clk;
  logic rst;

  io_bus_ctrl_if #(.NUM_SLOTS(NS), .ADR_W(AW), .DATA_W(DW)) bus ();

  io_bus_ctrl #(
    .NUM_SLOTS  (NS),
    .ADR_W      (AW),
    .DATA_W     (DW),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] dout;
    logic        err;
    int          waits;
    int          en_cyc;
    logic [7:0]  en_1h;
    int          rd_p;
    int          wr_p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input string nm, input logic [31:0] d, input logic e,
                          input int w, input int ec, input logic [7:0] oh,
                          input int rp, input int wp);
    exp_t x;
    x.nm = nm; x.dout = d; x.err = e; x.waits = w; x.en_cyc = ec;
    x.en_1h = oh; x.rd_p = rp; x.wr_p = wp;
    exp_q.push_back(x);
  endtask

  // Monitor: accumulate per-access observations, compare on completion.
  initial begin
    int         m_waits;
    int         m_en;
    int         m_rd;
    int         m_wr;
    logic [7:0] m_or;
    exp_t       x;
    m_waits = 0; m_en = 0; m_rd = 0; m_wr = 0; m_or = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_waits = 0; m_en = 0; m_rd = 0; m_wr = 0; m_or = '0;
      end else begin
        if (bus.memwait) m_waits++;
        if (bus.slot_rd) m_rd++;
        if (bus.slot_wr) m_wr++;
        if (bus.slot_en != '0) begin
          m_en++;
          m_or = m_or | bus.slot_en;
        end
        if (bus.io_en && (bus.rd || bus.wr) && !bus.memwait) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
          end else begin
            x = exp_q.pop_front();
            chk({x.nm, "_dout"},    bus.dout, x.dout);
            chk({x.nm, "_bus_err"}, bus.bus_err, x.err);
            chk({x.nm, "_memwait"}, m_waits, x.waits);
            chk({x.nm, "_en_cyc"},  m_en, x.en_cyc);
            chk({x.nm, "_slot_en"}, m_or, x.en_1h);
            chk({x.nm, "_rd_puls"}, m_rd, x.rd_p);
            chk({x.nm, "_wr_puls"}, m_wr, x.wr_p);
          end
          m_waits = 0; m_en = 0; m_rd = 0; m_wr = 0; m_or = '0;
        end
      end
    end
  end

  // Drive one cpu access; rdy_at is the ACCESS cycle (1-based) in which the
  // selected slot is ready, 0 for never. noise drives other slots' ready.
  task automatic do_acc(input string nm, input logic [23:0] a, input logic r,
                        input logic w, input int rdy_at, input logic [7:0] noise,
                        input logic [31:0] data, input logic clr_req);
    int         idx;
    logic [7:0] sel;
    bit         done;
    idx = int'(a[5:2]);
    sel = 8'(1 << idx);
    for (int i = 0; i < NS; i++) bus.slot_dout[i*DW +: DW] = 32'hDEAD_0000 | i;
    if (idx < NS) bus.slot_dout[idx*DW +: DW] = data;
    @(posedge clk); #1;
    bus.adr = a; bus.rd = r; bus.wr = w; bus.err_clr = clr_req;
    bus.slot_rdy = noise & ~sel;
    done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        bus.err_clr  = 1'b0;
        bus.slot_rdy = (c == rdy_at) ? sel : (noise & ~sel);
      end
      @(negedge clk);
      if (!bus.memwait) done = 1'b1;
    end
    chk({nm, "_finished"}, done, 1);
    @(posedge clk); #1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.slot_rdy = '0; bus.err_clr = 1'b0;
  endtask

  task automatic pulse_clr(input string nm);
    @(posedge clk); #1;
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk(nm, bus.bus_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.adr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.err_clr = 1'b0;
    bus.slot_dout = '0; bus.slot_rdy = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout",    bus.dout, 0);
    chk("rst_slot_en", bus.slot_en, 0);
    chk("rst_slot_rd", bus.slot_rd, 0);
    chk("rst_slot_wr", bus.slot_wr, 0);
    chk("rst_bus_err", bus.bus_err, 0);
    chk("rst_memwait", bus.memwait, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    push_exp("rd_s1_zw", 32'h1234_5678, 1'b0, 2, 1, 8'h02, 1, 0);
    do_acc("rd_s1_zw", 24'hFFFFC4, 1'b1, 1'b0, 1, 8'h00, 32'h1234_5678, 1'b0);

    push_exp("wr_s2", 32'h1234_5678, 1'b0, 5, 4, 8'h04, 0, 1);
    do_acc("wr_s2", 24'hFFFFC8, 1'b0, 1'b1, 4, 8'hFF, 32'h0000_0000, 1'b0);

    push_exp("rdwr_s3", 32'h1234_5678, 1'b0, 3, 2, 8'h08, 0, 1);
    do_acc("rdwr_s3", 24'hFFFFCC, 1'b1, 1'b1, 2, 8'h00, 32'h5555_AAAA, 1'b0);

    push_exp("rd_s7", 32'hA5A5_0007, 1'b0, 4, 3, 8'h80, 1, 0);
    do_acc("rd_s7", 24'hFFFFDC, 1'b1, 1'b0, 3, 8'h7F, 32'hA5A5_0007, 1'b0);

    // Reset in the middle of a slot-0 read that never gets ready.
    @(posedge clk); #1;
    bus.adr = 24'hFFFFC0; bus.rd = 1'b1; bus.slot_rdy = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_slot_en", bus.slot_en, 0);
    chk("midrst_memwait", bus.memwait, 0);
    chk("midrst_dout",    bus.dout, 0);
    chk("midrst_slot_rd", bus.slot_rd, 0);
    bus.rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    push_exp("rd_s0_after_rst", 32'hCAFE_0000, 1'b0, 2, 1, 8'h01, 1, 0);
    do_acc("rd_s0_after_rst", 24'hFFFFC0, 1'b1, 1'b0, 1, 8'h00, 32'hCAFE_0000, 1'b0);

    @(posedge clk); #1;
    bus.adr = 24'h000100; bus.rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nonio_io_en",   bus.io_en, 0);
      chk("nonio_memwait", bus.memwait, 0);
      chk("nonio_slot_en", bus.slot_en, 0);
      chk("nonio_slot_rd", bus.slot_rd, 0);
    end
    @(posedge clk); #1;
    bus.rd = 1'b0;

    push_exp("rd_idx9", 32'h0, 1'b1, 1, 0, 8'h00, 0, 0);
    do_acc("rd_idx9", 24'hFFFFE4, 1'b1, 1'b0, 0, 8'hFF, 32'h0, 1'b0);
    pulse_clr("clr_after_idx9");

    push_exp("wr_idx8_clr", 32'h0, 1'b1, 1, 0, 8'h00, 0, 0);
    do_acc("wr_idx8_clr", 24'hFFFFE0, 1'b0, 1'b1, 0, 8'h00, 32'h0, 1'b1);
    pulse_clr("clr_after_idx8");

`ifdef IO_TMO_EN
    push_exp("rd_s4_tmo", 32'h0, 1'b1, TMO + 1, TMO, 8'h10, 1, 0);
    do_acc("rd_s4_tmo", 24'hFFFFD0, 1'b1, 1'b0, 0, 8'h00, 32'h0BAD_F00D, 1'b0);
    pulse_clr("clr_after_tmo");
`else
    push_exp("rd_s4_slow", 32'h0BAD_F00D, 1'b0, 41, 40, 8'h10, 1, 0);
    do_acc("rd_s4_slow", 24'hFFFFD0, 1'b1, 1'b0, 40, 8'h00, 32'h0BAD_F00D, 1'b0);
`endif

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
